// File: rtl/pcie_tlp_stream_bridge.sv
// Avalon-ST bridge between the PCIe hard IP (phy_*) and the TLP fabric (tlp_*).
// Optional statistics counters are built only when PCIE_TLP_BRIDGE_STATS_EN is defined.
module pcie_tlp_stream_bridge #(
    parameter int DATA_W           = 256,
    parameter int PHY_EMPTY_W      = $clog2(DATA_W / 64),
    parameter int TLP_EMPTY_W      = $clog2(DATA_W / 32),
    parameter int RX_READY_LATENCY = 3,
    parameter int RX_FIFO_DEPTH    = 8
) (
    input  logic                   clk,
    input  logic                   reset,

    output logic [DATA_W-1:0]      phy_tx_st_data,
    output logic [PHY_EMPTY_W-1:0] phy_tx_st_empty,
    output logic                   phy_tx_st_startofpacket,
    output logic                   phy_tx_st_endofpacket,
    output logic                   phy_tx_st_valid,
    output logic                   phy_tx_st_error,
    input  logic                   phy_tx_st_ready,

    input  logic [DATA_W-1:0]      phy_rx_st_data,
    input  logic [PHY_EMPTY_W-1:0] phy_rx_st_empty,
    input  logic                   phy_rx_st_error,
    input  logic                   phy_rx_st_startofpacket,
    input  logic                   phy_rx_st_endofpacket,
    input  logic                   phy_rx_st_valid,
    output logic                   phy_rx_st_ready,

    input  logic [DATA_W-1:0]      tlp_tx_st_data,
    input  logic [TLP_EMPTY_W-1:0] tlp_tx_st_empty,
    input  logic                   tlp_tx_st_startofpacket,
    input  logic                   tlp_tx_st_endofpacket,
    input  logic                   tlp_tx_st_valid,
    output logic                   tlp_tx_st_ready,

    output logic [DATA_W-1:0]      tlp_rx_st_data,
    output logic [TLP_EMPTY_W-1:0] tlp_rx_st_empty,
    output logic                   tlp_rx_st_error,
    output logic                   tlp_rx_st_startofpacket,
    output logic                   tlp_rx_st_endofpacket,
    output logic                   tlp_rx_st_valid,
    input  logic                   tlp_rx_st_ready,

    output logic                   rx_overflow,
    output logic [31:0]            tx_pkt_count,
    output logic [31:0]            rx_pkt_count,
    output logic [31:0]            rx_err_count
);

    localparam int TX_W  = DATA_W + PHY_EMPTY_W + 2;
    localparam int RX_W  = DATA_W + PHY_EMPTY_W + 3;
    localparam int PTR_W = $clog2(RX_FIFO_DEPTH);
    localparam logic [PTR_W:0] DEPTH_V = (PTR_W + 1)'(RX_FIFO_DEPTH);
    localparam logic [PTR_W:0] LAT_V   = (PTR_W + 1)'(RX_READY_LATENCY);

    typedef enum logic {IDLE, PKT} tx_state_t;

    tx_state_t       tx_state;
    logic [1:0]      tx_occ;
    logic [1:0]      tx_occ_next;
    logic [TX_W-1:0] tx_head;
    logic [TX_W-1:0] tx_skid;
    logic [TX_W-1:0] tx_in;
    logic            tx_accept;
    logic            tx_fwd;
    logic            tx_pop;
    logic            tx_empty_unused;

    // The DWORD LSB of the fabric empty field has no QWORD equivalent.
    assign tx_empty_unused = tlp_tx_st_empty[0];
    assign tx_in     = {tlp_tx_st_data, tlp_tx_st_empty[TLP_EMPTY_W-1:1],
                        tlp_tx_st_startofpacket, tlp_tx_st_endofpacket};
    assign tx_accept = tlp_tx_st_valid & tlp_tx_st_ready;
    assign tx_fwd    = tx_accept & (tlp_tx_st_startofpacket | (tx_state == PKT));
    assign tx_pop    = phy_tx_st_valid & phy_tx_st_ready;

    assign phy_tx_st_valid = (tx_occ != 2'd0);
    assign phy_tx_st_error = 1'b0;
    assign {phy_tx_st_data, phy_tx_st_empty, phy_tx_st_startofpacket, phy_tx_st_endofpacket} = tx_head;

    always_comb begin
        tx_occ_next = tx_occ;
        unique case ({tx_fwd, tx_pop})
            2'b10:   tx_occ_next = tx_occ + 2'd1;
            2'b01:   tx_occ_next = tx_occ - 2'd1;
            default: tx_occ_next = tx_occ;
        endcase
    end

    // Framing: beats outside a packet without SOP are swallowed here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state <= IDLE;
        end else if (tx_fwd) begin
            tx_state <= tlp_tx_st_endofpacket ? IDLE : PKT;
        end
    end

    // Head is what the phy sees; skid catches the beat accepted while the head stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_occ          <= 2'd0;
            tlp_tx_st_ready <= 1'b0;
            tx_head         <= '0;
            tx_skid         <= '0;
        end else begin
            tx_occ          <= tx_occ_next;
            tlp_tx_st_ready <= (tx_occ_next < 2'd2);
            if (tx_pop) begin
                if (tx_occ == 2'd2) begin
                    tx_head <= tx_skid;
                end else if (tx_fwd) begin
                    tx_head <= tx_in;
                end
            end else if (tx_fwd) begin
                if (tx_occ == 2'd0) begin
                    tx_head <= tx_in;
                end else begin
                    tx_skid <= tx_in;
                end
            end
        end
    end

    logic [RX_W-1:0]        rx_mem [RX_FIFO_DEPTH];
    logic [PTR_W:0]         rx_wr_ptr;
    logic [PTR_W:0]         rx_rd_ptr;
    logic [PTR_W:0]         rx_count;
    logic [PTR_W:0]         rx_count_next;
    logic [PTR_W:0]         rx_free_next;
    logic                   rx_full;
    logic                   rx_empty;
    logic                   rx_wr;
    logic                   rx_rd;
    logic [PHY_EMPTY_W-1:0] rx_head_empty;

    assign rx_full  = (rx_wr_ptr[PTR_W] != rx_rd_ptr[PTR_W]) &&
                      (rx_wr_ptr[PTR_W-1:0] == rx_rd_ptr[PTR_W-1:0]);
    assign rx_empty = (rx_wr_ptr == rx_rd_ptr);
    assign rx_wr    = phy_rx_st_valid & ~rx_full;
    assign rx_rd    = ~rx_empty & tlp_rx_st_ready;

    assign rx_count      = rx_wr_ptr - rx_rd_ptr;
    assign rx_count_next = rx_count + {{PTR_W{1'b0}}, rx_wr} - {{PTR_W{1'b0}}, rx_rd};
    assign rx_free_next  = DEPTH_V - rx_count_next;

    assign {tlp_rx_st_data, rx_head_empty, tlp_rx_st_error,
            tlp_rx_st_startofpacket, tlp_rx_st_endofpacket} = rx_mem[rx_rd_ptr[PTR_W-1:0]];
    assign tlp_rx_st_empty = {rx_head_empty, 1'b0};
    assign tlp_rx_st_valid = ~rx_empty;

    always_ff @(posedge clk) begin
        if (rx_wr) begin
            rx_mem[rx_wr_ptr[PTR_W-1:0]] <= {phy_rx_st_data, phy_rx_st_empty, phy_rx_st_error,
                                             phy_rx_st_startofpacket, phy_rx_st_endofpacket};
        end
    end

    // Ready drops while fewer slots remain than beats the phy may still send after seeing it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_wr_ptr       <= '0;
            rx_rd_ptr       <= '0;
            phy_rx_st_ready <= 1'b0;
            rx_overflow     <= 1'b0;
        end else begin
            if (rx_wr) begin
                rx_wr_ptr <= rx_wr_ptr + 1'b1;
            end
            if (rx_rd) begin
                rx_rd_ptr <= rx_rd_ptr + 1'b1;
            end
            if (phy_rx_st_valid && rx_full) begin
                rx_overflow <= 1'b1;
            end
            phy_rx_st_ready <= (rx_free_next > LAT_V);
        end
    end

`ifdef PCIE_TLP_BRIDGE_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_pkt_count <= 32'd0;
            rx_pkt_count <= 32'd0;
            rx_err_count <= 32'd0;
        end else begin
            if (tx_pop && phy_tx_st_endofpacket) begin
                tx_pkt_count <= tx_pkt_count + 32'd1;
            end
            if (rx_rd && tlp_rx_st_endofpacket) begin
                rx_pkt_count <= rx_pkt_count + 32'd1;
            end
            if (rx_rd && tlp_rx_st_error) begin
                rx_err_count <= rx_err_count + 32'd1;
            end
        end
    end
`else
    assign tx_pkt_count = 32'd0;
    assign rx_pkt_count = 32'd0;
    assign rx_err_count = 32'd0;
`endif

endmodule

// File: tb/tb_pcie_tlp_stream_bridge.sv
// Directed self-checking bench for pcie_tlp_stream_bridge with a TX/RX scoreboard and a latency-3 phy RX model.
module tb_pcie_tlp_stream_bridge;

    localparam int DW    = 256;
    localparam int PEW   = 2;
    localparam int TEW   = 3;
    localparam int DEPTH = 8;
    localparam int CW    = DW + 8;
`ifdef PCIE_TLP_BRIDGE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [DW-1:0]  phy_tx_st_data;
    logic [PEW-1:0] phy_tx_st_empty;
    logic           phy_tx_st_startofpacket, phy_tx_st_endofpacket, phy_tx_st_valid, phy_tx_st_error;
    logic           phy_tx_st_ready;
    logic [DW-1:0]  phy_rx_st_data;
    logic [PEW-1:0] phy_rx_st_empty;
    logic           phy_rx_st_error, phy_rx_st_startofpacket, phy_rx_st_endofpacket, phy_rx_st_valid;
    logic           phy_rx_st_ready;
    logic [DW-1:0]  tlp_tx_st_data;
    logic [TEW-1:0] tlp_tx_st_empty;
    logic           tlp_tx_st_startofpacket, tlp_tx_st_endofpacket, tlp_tx_st_valid, tlp_tx_st_ready;
    logic [DW-1:0]  tlp_rx_st_data;
    logic [TEW-1:0] tlp_rx_st_empty;
    logic           tlp_rx_st_error, tlp_rx_st_startofpacket, tlp_rx_st_endofpacket, tlp_rx_st_valid;
    logic           tlp_rx_st_ready;
    logic           rx_overflow;
    logic [31:0]    tx_pkt_count, rx_pkt_count, rx_err_count;

    always #5 clk = ~clk;

    pcie_tlp_stream_bridge dut (
        .clk                     (clk),
        .reset                   (reset),
        .phy_tx_st_data          (phy_tx_st_data),
        .phy_tx_st_empty         (phy_tx_st_empty),
        .phy_tx_st_startofpacket (phy_tx_st_startofpacket),
        .phy_tx_st_endofpacket   (phy_tx_st_endofpacket),
        .phy_tx_st_valid         (phy_tx_st_valid),
        .phy_tx_st_error         (phy_tx_st_error),
        .phy_tx_st_ready         (phy_tx_st_ready),
        .phy_rx_st_data          (phy_rx_st_data),
        .phy_rx_st_empty         (phy_rx_st_empty),
        .phy_rx_st_error         (phy_rx_st_error),
        .phy_rx_st_startofpacket (phy_rx_st_startofpacket),
        .phy_rx_st_endofpacket   (phy_rx_st_endofpacket),
        .phy_rx_st_valid         (phy_rx_st_valid),
        .phy_rx_st_ready         (phy_rx_st_ready),
        .tlp_tx_st_data          (tlp_tx_st_data),
        .tlp_tx_st_empty         (tlp_tx_st_empty),
        .tlp_tx_st_startofpacket (tlp_tx_st_startofpacket),
        .tlp_tx_st_endofpacket   (tlp_tx_st_endofpacket),
        .tlp_tx_st_valid         (tlp_tx_st_valid),
        .tlp_tx_st_ready         (tlp_tx_st_ready),
        .tlp_rx_st_data          (tlp_rx_st_data),
        .tlp_rx_st_empty         (tlp_rx_st_empty),
        .tlp_rx_st_error         (tlp_rx_st_error),
        .tlp_rx_st_startofpacket (tlp_rx_st_startofpacket),
        .tlp_rx_st_endofpacket   (tlp_rx_st_endofpacket),
        .tlp_rx_st_valid         (tlp_rx_st_valid),
        .tlp_rx_st_ready         (tlp_rx_st_ready),
        .rx_overflow             (rx_overflow),
        .tx_pkt_count            (tx_pkt_count),
        .rx_pkt_count            (rx_pkt_count),
        .rx_err_count            (rx_err_count)
    );

    int checks = 0;
    int errors = 0;

    logic [DW+PEW+1:0] tx_exp[$];
    logic [DW+PEW+2:0] rx_exp[$];
    bit                tx_in_pkt = 1'b0;
    bit                tx_accepted = 1'b0;
    int unsigned       exp_tx_pkt = 0;
    int unsigned       exp_rx_pkt = 0;
    int unsigned       exp_rx_err = 0;
    int                tx_stall = 0;
    int                stall_acc = 0;
    int                ready_low = 0;
    bit [2:0]          rdy_hist = 3'b000;
    int                rx_remaining = 0;
    bit                rx_force = 1'b0;
    bit                rx_special = 1'b0;
    int unsigned       rx_seq = 0;

    task automatic checkOutput(input string tag, input logic [CW-1:0] observed, input logic [CW-1:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Called one ns before the rising edge: decides what transfers at that edge.
    task automatic sample();
        logic [DW+PEW+1:0] tb;
        logic [DW+PEW+2:0] rb;
        bit                full_before;
        tx_accepted = tlp_tx_st_valid && tlp_tx_st_ready;
        if (tx_accepted && (tlp_tx_st_startofpacket || tx_in_pkt)) begin
            tx_exp.push_back({tlp_tx_st_data, PEW'(tlp_tx_st_empty >> 1),
                              tlp_tx_st_startofpacket, tlp_tx_st_endofpacket});
            tx_in_pkt = !tlp_tx_st_endofpacket;
        end
        if (!phy_tx_st_ready && tx_accepted) stall_acc++;
        if (tlp_tx_st_valid && !tlp_tx_st_ready) ready_low++;
        if (phy_tx_st_valid && phy_tx_st_ready) begin
            if (tx_exp.size() == 0) begin
                checkOutput("tx spurious beat", 1'b1, 1'b0);
            end else begin
                tb = tx_exp.pop_front();
                checkOutput("tx beat", {phy_tx_st_data, phy_tx_st_empty,
                                        phy_tx_st_startofpacket, phy_tx_st_endofpacket}, tb);
                if (tb[0]) exp_tx_pkt++;
            end
        end
        checkOutput("rx valid", tlp_rx_st_valid, rx_exp.size() != 0);
        full_before = (rx_exp.size() == DEPTH);
        if (rx_exp.size() != 0 && tlp_rx_st_ready) begin
            rb = rx_exp.pop_front();
            checkOutput("rx beat", {tlp_rx_st_data, tlp_rx_st_empty, tlp_rx_st_error,
                                    tlp_rx_st_startofpacket, tlp_rx_st_endofpacket},
                        {rb[DW+4:5], rb[4:3], 1'b0, rb[2:0]});
            if (rb[0]) exp_rx_pkt++;
            if (rb[2]) exp_rx_err++;
        end
        if (phy_rx_st_valid && !full_before) begin
            rx_exp.push_back({phy_rx_st_data, phy_rx_st_empty, phy_rx_st_error,
                              phy_rx_st_startofpacket, phy_rx_st_endofpacket});
        end
    endtask

    // Phy RX model: sends only if ready was high three cycles earlier (unless forced).
    task automatic driveRx();
        bit go;
        go = (rx_remaining > 0) && (rx_force || rdy_hist[2]);
        rdy_hist = {rdy_hist[1:0], phy_rx_st_ready};
        phy_rx_st_valid = go;
        if (go) begin
            rx_seq++;
            rx_remaining--;
            phy_rx_st_data = {8{rx_seq}};
            if (rx_special) begin
                phy_rx_st_empty = 2'd2;
                phy_rx_st_error = 1'b1;
                phy_rx_st_startofpacket = 1'b1;
                phy_rx_st_endofpacket = 1'b1;
                rx_special = 1'b0;
            end else begin
                phy_rx_st_empty = PEW'(rx_seq);
                phy_rx_st_error = 1'b0;
                phy_rx_st_startofpacket = (rx_seq % 4 == 1);
                phy_rx_st_endofpacket = (rx_seq % 4 == 0);
            end
        end
    endtask

    task automatic tick();
        #4;
        sample();
        @(negedge clk);
        if (tx_stall > 0) begin
            phy_tx_st_ready = 1'b0;
            tx_stall--;
        end else begin
            phy_tx_st_ready = 1'b1;
        end
        driveRx();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic applyStimulus(input logic [DW-1:0] d, input logic [TEW-1:0] e, input logic s, input logic p);
        bit ok;
        ok = 1'b0;
        tlp_tx_st_data = d;
        tlp_tx_st_empty = e;
        tlp_tx_st_startofpacket = s;
        tlp_tx_st_endofpacket = p;
        tlp_tx_st_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (tx_accepted) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) checkOutput("tx accept timeout", tx_accepted, 1'b1);
        tlp_tx_st_valid = 1'b0;
    endtask

    initial begin
        logic [DW-1:0] d;
        phy_tx_st_ready = 1'b1;
        phy_rx_st_data = '0;
        phy_rx_st_empty = '0;
        phy_rx_st_error = 1'b0;
        phy_rx_st_startofpacket = 1'b0;
        phy_rx_st_endofpacket = 1'b0;
        phy_rx_st_valid = 1'b0;
        tlp_tx_st_data = '0;
        tlp_tx_st_empty = '0;
        tlp_tx_st_startofpacket = 1'b0;
        tlp_tx_st_endofpacket = 1'b0;
        tlp_tx_st_valid = 1'b0;
        tlp_rx_st_ready = 1'b1;

        @(negedge clk);
        @(negedge clk);
        checkOutput("rst tlp_tx_ready", tlp_tx_st_ready, 1'b0);
        checkOutput("rst phy_rx_ready", phy_rx_st_ready, 1'b0);
        checkOutput("rst phy_tx_valid", phy_tx_st_valid, 1'b0);
        checkOutput("rst tlp_rx_valid", tlp_rx_st_valid, 1'b0);
        checkOutput("rst overflow", rx_overflow, 1'b0);
        checkOutput("rst tx_pkt_count", tx_pkt_count, 32'd0);
        reset = 1'b0;
        tick();
        checkOutput("rel tlp_tx_ready", tlp_tx_st_ready, 1'b1);
        checkOutput("rel phy_rx_ready", phy_rx_st_ready, 1'b1);
        idle(3);

        $display("[TB] test 1: 3-beat TX packet");
        checkOutput("t1 phy idle", phy_tx_st_valid, 1'b0);
        d = {8{32'hA0A0_0000}};
        applyStimulus(d, 3'd0, 1'b1, 1'b0);
        checkOutput("t1 beat0 latency", phy_tx_st_valid, 1'b1);
        checkOutput("t1 beat0 data", phy_tx_st_data, d);
        checkOutput("t1 beat0 sop", phy_tx_st_startofpacket, 1'b1);
        checkOutput("t1 tx error", phy_tx_st_error, 1'b0);
        applyStimulus({8{32'hA0A0_0001}}, 3'd2, 1'b0, 1'b0);
        d = {8{32'hA0A0_0002}};
        applyStimulus(d, 3'd3, 1'b0, 1'b1);
        checkOutput("t1 beat2 data", phy_tx_st_data, d);
        checkOutput("t1 empty map", phy_tx_st_empty, 2'd1);
        checkOutput("t1 eop", phy_tx_st_endofpacket, 1'b1);
        tick();
        checkOutput("t1 drained", phy_tx_st_valid, 1'b0);

        $display("[TB] test 2: phy stall mid-packet");
        stall_acc = 0;
        ready_low = 0;
        phy_tx_st_ready = 1'b0;
        tx_stall = 4;
        for (int i = 0; i < 5; i++) begin
            applyStimulus({8{32'hB000_0000 + 32'(i)}}, TEW'(i), i == 0, i == 4);
        end
        idle(4);
        checkOutput("t2 accepts during stall", stall_acc, 2);
        checkOutput("t2 ready low cycles", ready_low, 4);
        checkOutput("t2 all delivered", tx_exp.size(), 0);
        checkOutput("t2 phy idle", phy_tx_st_valid, 1'b0);

        $display("[TB] test 3: RX backpressure");
        tlp_rx_st_ready = 1'b0;
        rx_remaining = 12;
        idle(15);
        checkOutput("t3 phy held off", rx_remaining, 4);
        checkOutput("t3 fifo level", rx_exp.size(), DEPTH);
        checkOutput("t3 ready low", phy_rx_st_ready, 1'b0);
        checkOutput("t3 no overflow", rx_overflow, 1'b0);
        tlp_rx_st_ready = 1'b1;
        idle(30);
        checkOutput("t3 all sent", rx_remaining, 0);
        checkOutput("t3 drained", tlp_rx_st_valid, 1'b0);
        checkOutput("t3 still no overflow", rx_overflow, 1'b0);

        $display("[TB] test 4: forced RX overflow");
        tlp_rx_st_ready = 1'b0;
        rx_force = 1'b1;
        rx_remaining = 10;
        idle(12);
        checkOutput("t4 overflow set", rx_overflow, 1'b1);
        checkOutput("t4 fifo level", rx_exp.size(), DEPTH);
        rx_force = 1'b0;
        tlp_rx_st_ready = 1'b1;
        idle(12);
        checkOutput("t4 overflow sticky", rx_overflow, 1'b1);
        checkOutput("t4 drained", tlp_rx_st_valid, 1'b0);

        $display("[TB] test 5: RX empty mapping and error");
        tlp_rx_st_ready = 1'b0;
        rx_special = 1'b1;
        rx_remaining = 1;
        idle(3);
        checkOutput("t5 valid", tlp_rx_st_valid, 1'b1);
        checkOutput("t5 tlp empty", tlp_rx_st_empty, 3'd4);
        checkOutput("t5 error", tlp_rx_st_error, 1'b1);
        tlp_rx_st_ready = 1'b1;
        idle(2);
        checkOutput("t5 rx_err_count", rx_err_count, STATS ? 32'd1 : 32'd0);
        checkOutput("t5 rx_pkt_count", rx_pkt_count, STATS ? exp_rx_pkt : 32'd0);
        checkOutput("t5 tx_pkt_count", tx_pkt_count, STATS ? 32'd2 : 32'd0);

        $display("[TB] test 6: reset mid-packet");
        phy_tx_st_ready = 1'b0;
        tx_stall = 20;
        applyStimulus({8{32'hC0C0_0000}}, 3'd0, 1'b1, 1'b0);
        tlp_rx_st_ready = 1'b0;
        rx_remaining = 2;
        idle(6);
        checkOutput("t6 rx pending", tlp_rx_st_valid, 1'b1);
        checkOutput("t6 tx pending", phy_tx_st_valid, 1'b1);
        rx_remaining = 0;
        #1 reset = 1'b1;
        #1;
        checkOutput("t6 rst tlp_rx_valid", tlp_rx_st_valid, 1'b0);
        checkOutput("t6 rst phy_tx_valid", phy_tx_st_valid, 1'b0);
        checkOutput("t6 rst tlp_tx_ready", tlp_tx_st_ready, 1'b0);
        checkOutput("t6 rst phy_rx_ready", phy_rx_st_ready, 1'b0);
        checkOutput("t6 rst overflow", rx_overflow, 1'b0);
        checkOutput("t6 rst rx_err_count", rx_err_count, 32'd0);
        tx_exp.delete();
        rx_exp.delete();
        tx_in_pkt = 1'b0;
        exp_tx_pkt = 0;
        exp_rx_pkt = 0;
        exp_rx_err = 0;
        tx_stall = 0;
        phy_tx_st_ready = 1'b1;
        tlp_rx_st_ready = 1'b1;
        @(negedge clk);
        tick();
        reset = 1'b0;
        tick();
        checkOutput("t6 rel phy_rx_ready", phy_rx_st_ready, 1'b1);
        checkOutput("t6 rel tlp_tx_ready", tlp_tx_st_ready, 1'b1);
        checkOutput("t6 rel fifo empty", tlp_rx_st_valid, 1'b0);
        applyStimulus({8{32'hD0D0_0000}}, 3'd0, 1'b0, 1'b1);
        tick();
        checkOutput("t6 orphan beat dropped", phy_tx_st_valid, 1'b0);
        applyStimulus({8{32'hD0D0_0001}}, 3'd1, 1'b1, 1'b1);
        checkOutput("t6 single beat out", phy_tx_st_valid, 1'b1);
        idle(2);
        checkOutput("t6 tx delivered", tx_exp.size(), 0);
        checkOutput("t6 tx_pkt_count", tx_pkt_count, STATS ? 32'd1 : 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
